// File: rtl/e_clk_pkg.sv
// Shared types, reset defaults and helpers for the E-clock window generator.
package e_clk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StAct,
        StHold
    } win_state_e;

    localparam int unsigned DefRise = 0;
    localparam int unsigned DefHold = 4;

    // Ceiling log2, never less than 1 so a single-entry select still has a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'(1) << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/e_clk_window_gen_if.sv
// Configuration write bus shared by all window channels.
interface e_clk_window_gen_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_rise;
    logic [CNT_W-1:0] cfg_hold;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_rise,
        output cfg_hold
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_rise,
        input cfg_hold
    );
endinterface

// File: rtl/e_win_chan.sv
// One window channel: pending/active config, IDLE/PRE/ACT/HOLD FSM and delay counter.
module e_win_chan
    import e_clk_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEF_RISE = DefRise,
    parameter int unsigned DEF_HOLD = DefHold
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_cfg_rise,
    input  logic [CNT_W-1:0] i_cfg_hold,
    input  logic             i_en,
    input  logic             i_rise,
    input  logic             i_fall,
    input  logic             i_kill,
    output logic             o_win
);
    logic [CNT_W-1:0] r_pend_rise, r_pend_hold;
    logic [CNT_W-1:0] r_act_rise, r_act_hold;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    win_state_e       r_state, w_state_nxt;
    logic             r_win;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_rise <= CNT_W'(DEF_RISE);
            r_pend_hold <= CNT_W'(DEF_HOLD);
            r_act_rise  <= CNT_W'(DEF_RISE);
            r_act_hold  <= CNT_W'(DEF_HOLD);
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_win       <= 1'b0;
        end else begin
            // Copy happens before the write lands, so a write in the rise cycle waits a period.
            if (i_rise) begin
                r_act_rise <= r_pend_rise;
                r_act_hold <= r_pend_hold;
            end
            if (i_we) begin
                r_pend_rise <= i_cfg_rise;
                r_pend_hold <= i_cfg_hold;
            end
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_win   <= (w_state_nxt == StAct) || (w_state_nxt == StHold);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_kill || !i_en) begin
            w_state_nxt = StIdle;
        end else if (i_rise) begin
            // The period starting now uses the config being copied this cycle.
            if (r_pend_rise == '0) begin
                w_state_nxt = StAct;
            end else begin
                w_state_nxt = StPre;
                w_cnt_nxt   = r_pend_rise - 1'b1;
            end
        end else begin
            case (r_state)
                StPre: begin
                    if (i_fall) begin
                        w_state_nxt = StIdle;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = StAct;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                StAct: begin
                    if (i_fall) begin
                        if (r_act_hold == '0) begin
                            w_state_nxt = StIdle;
                        end else begin
                            w_state_nxt = StHold;
                            w_cnt_nxt   = r_act_hold - 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/e_clk_window_gen.sv
// E-clock synchroniser, edge detector and loss watchdog driving N_CH window channels.
module e_clk_window_gen
    import e_clk_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOST_CYC    = 255,
    parameter int unsigned DEF_RISE    = DefRise,
    parameter int unsigned DEF_HOLD    = DefHold
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_e_clk,
    e_clk_window_gen_if.slave i_cfg,
    input  logic [N_CH-1:0]   i_ch_en,
    output logic [N_CH-1:0]   o_win,
    output logic              o_e_rise,
    output logic              o_e_fall,
    output logic              o_e_lost
);
    localparam int unsigned CH_W = clog2_min1(N_CH);
    localparam int unsigned WD_W = clog2_min1(LOST_CYC + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_e_d;
    logic [WD_W-1:0]        r_wd;
    logic                   w_e_s, w_rise, w_fall, w_kill;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_e_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_e_clk};
            r_e_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_e_s  = r_sync[SYNC_STAGES-1];
    assign w_rise = w_e_s & ~r_e_d;
    assign w_fall = ~w_e_s & r_e_d;

    // Holds the number of cycles since the last edge, saturating at LOST_CYC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wd <= '0;
        end else if (w_rise || w_fall) begin
            r_wd <= WD_W'(1);
        end else if (r_wd != WD_W'(LOST_CYC)) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign o_e_lost = (r_wd == WD_W'(LOST_CYC));
    assign o_e_rise = w_rise;
    assign o_e_fall = w_fall;
    // A rise in the last lost cycle restarts channels instead of idling them.
    assign w_kill   = o_e_lost & ~w_rise;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        logic w_we;
        assign w_we = i_cfg.cfg_we && (i_cfg.cfg_ch == CH_W'(g));

        e_win_chan #(
            .CNT_W    (CNT_W),
            .DEF_RISE (DEF_RISE),
            .DEF_HOLD (DEF_HOLD)
        ) u_chan (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_we       (w_we),
            .i_cfg_rise (i_cfg.cfg_rise),
            .i_cfg_hold (i_cfg.cfg_hold),
            .i_en       (i_ch_en[g]),
            .i_rise     (w_rise),
            .i_fall     (w_fall),
            .i_kill     (w_kill),
            .o_win      (o_win[g])
        );
    end

endmodule

// File: tb/tb_e_clk_window_gen.sv
// Scoreboard bench: a period-level window model predicts every output cycle by cycle.
module tb_e_clk_window_gen;
    import e_clk_pkg::*;

    localparam int N    = 3;
    localparam int CW   = 8;
    localparam int S    = 2;
    localparam int LOST = 255;
    localparam int DEFR = 0;
    localparam int DEFH = 4;
    localparam int MAXC = 40000;
    localparam int INF  = 32'h3fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_in;
    logic         e_in;
    logic [N-1:0] en_in;
    logic [N-1:0] w_win;
    logic         w_rise, w_fall, w_lost;

    e_clk_window_gen_if #(.CH_W(2), .CNT_W(CW)) cfg_if ();

    e_clk_window_gen #(
        .N_CH        (N),
        .CNT_W       (CW),
        .SYNC_STAGES (S),
        .LOST_CYC    (LOST),
        .DEF_RISE    (DEFR),
        .DEF_HOLD    (DEFH)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_in),
        .i_e_clk  (e_in),
        .i_cfg    (cfg_if.slave),
        .i_ch_en  (en_in),
        .o_win    (w_win),
        .o_e_rise (w_rise),
        .o_e_fall (w_fall),
        .o_e_lost (w_lost)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] win;
        logic         rise;
        logic         fall;
        logic         lost;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model state: E sample history, detected edges, and per-channel window span [st, off).
    bit e_hist [MAXC];
    bit rise_h [MAXC];
    bit fall_h [MAXC];
    bit lost_h [MAXC];
    int pend_r [N];
    int pend_h [N];
    int act_r  [N];
    int act_h  [N];
    int st     [N];
    int off    [N];
    int ref_c  = 0;

    function automatic bit hist(input int k);
        return (k < 0) ? 1'b0 : e_hist[k];
    endfunction

    task automatic model_step(input int c);
        exp_t x;
        bit   ev_r, ev_f;
        e_hist[c] = e_in;
        if (rst_in) begin
            for (int k = c - S - 1; k <= c; k++) begin
                if (k >= 0) e_hist[k] = 1'b0;
            end
            for (int ch = 0; ch < N; ch++) begin
                pend_r[ch] = DEFR; pend_h[ch] = DEFH;
                act_r[ch]  = DEFR; act_h[ch]  = DEFH;
                st[ch] = INF; off[ch] = INF;
            end
            ref_c = c + 1;
        end else begin
            ev_r = rise_h[c];
            ev_f = fall_h[c];
            if (ev_r || ev_f) ref_c = c;
            for (int ch = 0; ch < N; ch++) begin
                if (ev_r) begin
                    act_r[ch] = pend_r[ch];
                    act_h[ch] = pend_h[ch];
                    st[ch]    = c + 1 + act_r[ch];
                    off[ch]   = INF;
                end else if (ev_f) begin
                    if (st[ch] <= c && off[ch] == INF) off[ch] = c + 1 + act_h[ch];
                    else if (st[ch] > c) st[ch] = INF;
                end
                if (!en_in[ch] || (lost_h[c] && !ev_r)) begin
                    st[ch] = INF; off[ch] = INF;
                end
                if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == ch) begin
                    pend_r[ch] = int'(cfg_if.cfg_rise);
                    pend_h[ch] = int'(cfg_if.cfg_hold);
                end
            end
        end
        rise_h[c+1] = hist(c + 1 - S) & !hist(c - S);
        fall_h[c+1] = !hist(c + 1 - S) & hist(c - S);
        lost_h[c+1] = ((c + 1 - ref_c) >= LOST);
        x.cyc  = c + 1;
        x.rise = rise_h[c+1];
        x.fall = fall_h[c+1];
        x.lost = lost_h[c+1];
        for (int ch = 0; ch < N; ch++) x.win[ch] = (st[ch] <= c + 1) && (c + 1 < off[ch]);
        sb_q.push_back(x);
    endtask

    task automatic tick();
        model_step(cyc);
        @(posedge clk);
        cyc++;
        #1;
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int r, input int h);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = 2'(ch);
        cfg_if.cfg_rise = CW'(r);
        cfg_if.cfg_hold = CW'(h);
        tick();
    endtask

    task automatic period(input int hi, input int lo);
        e_in = 1'b1;
        repeat (hi) tick();
        e_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic rand_cycle();
        if ($urandom_range(0, 9) == 0) begin
            cfg_if.cfg_we   = 1'b1;
            cfg_if.cfg_ch   = 2'($urandom_range(0, 3));
            cfg_if.cfg_rise = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 20));
            cfg_if.cfg_hold = CW'($urandom_range(0, 20));
        end
        if ($urandom_range(0, 149) == 0) en_in[$urandom_range(0, N - 1)] ^= 1'b1;
        rst_in = ($urandom_range(0, 2999) == 0);
        tick();
        rst_in = 1'b0;
    endtask

    // Monitor: compare whenever the head of the scoreboard is due.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                x = sb_q.pop_front();
                checks++;
                if (x.cyc != cyc) begin
                    failures++;
                    $display("FAIL sb_order cyc=%0d got entry for cyc=%0d", cyc, x.cyc);
                end else if (w_win !== x.win || w_rise !== x.rise || w_fall !== x.fall ||
                             w_lost !== x.lost) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d win=%b/%b rise=%b/%b fall=%b/%b lost=%b/%b (got/exp)",
                             cyc, w_win, x.win, w_rise, x.rise, w_fall, x.fall, w_lost, x.lost);
                end
            end
        end
    end

    initial begin
        int hi, lo;
        rst_in          = 1'b1;
        e_in            = 1'b0;
        en_in           = '0;
        cfg_if.cfg_we   = 1'b0;
        cfg_if.cfg_ch   = '0;
        cfg_if.cfg_rise = '0;
        cfg_if.cfg_hold = '0;
        @(posedge clk);
        #1;
        repeat (4) tick();
        rst_in = 1'b0;
        en_in  = '1;
        repeat (5) tick();

        cfg_write(0, 3, 5);
        cfg_write(1, 60, 4);
        cfg_write(2, 0, 10);
        repeat (2) period(50, 50);
        repeat (3) period(50, 6);

        // Rise-cycle write: takes effect one period later.
        e_in = 1'b1;
        repeat (2) tick();
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_ch   = 2'd0;
        cfg_if.cfg_rise = CW'(7);
        cfg_if.cfg_hold = CW'(5);
        repeat (48) tick();
        e_in = 1'b0;
        repeat (50) tick();
        repeat (2) period(50, 50);

        period(300, 50);
        period(50, 50);

        e_in = 1'b1;
        repeat (20) tick();
        en_in = 3'b010;
        repeat (5) tick();
        en_in = '1;
        repeat (25) tick();
        e_in = 1'b0;
        repeat (50) tick();
        period(50, 50);

        cfg_write(3, 9, 9);
        period(50, 50);

        for (int p = 0; p < 80; p++) begin
            hi = ($urandom_range(0, 24) == 0) ? int'($urandom_range(260, 320)) : int'($urandom_range(1, 40));
            lo = ($urandom_range(0, 24) == 0) ? int'($urandom_range(260, 320)) : int'($urandom_range(1, 40));
            e_in = 1'b1;
            for (int k = 0; k < hi; k++) rand_cycle();
            e_in = 1'b0;
            for (int k = 0; k < lo; k++) rand_cycle();
            if (cyc > 30000) break;
        end

        // Reset while channel 2 is inside its window.
        en_in = '1;
        repeat (60) tick();
        cfg_write(2, 0, 10);
        period(50, 50);
        e_in = 1'b1;
        repeat (10) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        repeat (40) tick();
        e_in = 1'b0;
        repeat (50) tick();
        repeat (2) period(50, 50);

        #20;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_clk_window_gen.md
E_CLK_WINDOW_GEN -- requirements
Module: e_clk_window_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent window channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of delay counters and config fields.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for i_e_clk (>=2).
REQ-004 SHALL have parameter LOST_CYC, default 255, i_clk cycles without an E edge before declaring E lost.
REQ-005 SHALL have parameters DEF_RISE, default 0, and DEF_HOLD, default 4, reset values of every channel's config.
REQ-006 SHALL have port i_clk, input, 1, fast PLL clock; the block uses one clock.
REQ-007 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port i_e_clk, input, 1, 6809 E clock, asynchronous to i_clk.
REQ-009 SHALL have port i_cfg_we, input, 1, config write strobe.
REQ-010 SHALL have port i_cfg_ch, input, clog2(N_CH) (min 1), channel selected for the write.
REQ-011 SHALL have port i_cfg_rise, input, CNT_W, delay from E rise to window assert.
REQ-012 SHALL have port i_cfg_hold, input, CNT_W, hold time after E fall before window deassert.
REQ-013 SHALL have port i_ch_en, input, N_CH, per-channel enable.
REQ-014 SHALL have port o_win, output, N_CH, active-high window per channel, registered.
REQ-015 SHALL have ports o_e_rise and o_e_fall, output, 1 each, single-cycle pulses on synchronised E edges.
REQ-016 SHALL have port o_e_lost, output, 1, high while E is declared lost.

Function
REQ-017 SHALL pass i_e_clk through SYNC_STAGES flops, then one edge-detect flop; cycle T is the cycle in which o_e_rise/o_e_fall is high.
REQ-018 SHALL write i_cfg_rise/i_cfg_hold into the pending registers of channel i_cfg_ch when i_cfg_we=1; i_cfg_ch >= N_CH is ignored.
REQ-019 SHALL copy pending into active config for every channel in rise cycle T; a write in the same cycle as a rise applies to the next E period.
REQ-020 SHALL run per-channel FSM states IDLE, PRE, ACT, HOLD; o_win=1 only in ACT and HOLD.
REQ-021 IDLE->PRE on rise when channel enabled and rise>0; IDLE->ACT on rise when rise=0; o_win high at T+1.
REQ-022 PRE counts rise cycles; ->ACT when count expires, so o_win is high at T+1+rise.
REQ-023 PRE->IDLE on fall before expiry; window suppressed for that period, and no HOLD.
REQ-024 ACT->HOLD on fall, or ->IDLE if hold=0; o_win low at T+1+hold relative to fall cycle T.
REQ-025 HOLD->PRE or ACT per REQ-021 on a rise before hold expiry; with rise=0, o_win stays high without a gap.
REQ-026 i_ch_en deassert SHALL force that channel to IDLE next cycle; reassert takes effect at the next rise only.
REQ-027 SHALL count cycles since the last sync edge, saturating; o_e_lost=1 when count reaches LOST_CYC; all channels then go IDLE and o_win=0.
REQ-028 SHALL clear o_e_lost in the cycle after the next detected edge; a rise edge in that cycle starts channels normally.
REQ-029 SHALL keep counters within CNT_W with no wrap; max delay = 2^CNT_W-1 cycles.

Reset
REQ-030 On i_reset=1 at a clock edge: o_win=0, o_e_rise=0, o_e_fall=0, o_e_lost=0, FSMs IDLE, sync/edge flops 0, watchdog 0, pending and active config = DEF_RISE/DEF_HOLD.
REQ-031 Reset mid-window SHALL drop o_win the cycle after reset asserts; the first edge after release SHALL be a rise, seen only if E is sampled 0 then 1.

Structure
REQ-032 SHALL place the FSM state enum, default constants, and the clog2 helper in shared package e_clk_pkg.
REQ-033 SHALL implement one channel (config regs, FSM, counter) in sub-module e_win_chan, instantiated N_CH times by generate.

Verification
REQ-034 Ch0 rise=3, hold=5, E period 100 cycles, 50% duty -> o_win[0] rises at T+4 after rise cycle T and falls 6 cycles after fall cycle.
REQ-035 Ch1 rise=60 with 50-cycle E high -> o_win[1] never asserts; FSM returns IDLE at fall.
REQ-036 Ch2 rise=0, hold=10, E low for 6 cycles -> o_win[2] continuously high across the period boundary.
REQ-037 Write ch0 rise=7 in rise cycle T -> current period uses old value, next period uses 7.
REQ-038 E held high for 300 cycles with LOST_CYC=255 -> o_e_lost=1 at cycle 255 after the last edge, all o_win=0; o_e_lost clears after the next fall edge.
REQ-039 Assert i_reset during ACT -> o_win=0 the next cycle; config reads back as DEF_RISE/DEF_HOLD in behaviour.
